mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory between the instruction-fetch requester (IF) and the data-access requester (MEM stage).
- Each requester uses a req/gnt handshake; read data returns with an rvalid pulse.
- Only one transaction is outstanding at a time.
- Data accesses have fixed priority over instruction fetches, with a starvation guard.
- Sits between the pipeline core and a unified IMEM/DMEM array, enabling a von-Neumann memory build.

Parameters:
- ADDR_W, 32, address width of requesters and memory port
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles (legal 1..4); mem_rdata is valid MEM_LAT cycles after the mem_en cycle
- STARVE_MAX, 4, consecutive data grants while if_req is pending before IF is forced a grant (legal 1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  fetch read data (registered)
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  one-cycle pulse, d_rdata valid (reads only)
- d_rdata  out  DATA_W  load data (registered)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  a read is in flight (state RD_WAIT)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE; latency counter, starvation counter and source register = 0.
  - if_rvalid, d_rvalid, if_rdata, d_rdata = 0; busy = 0.
  - Reset mid-read discards the read; no rvalid is ever produced for it.
- States: IDLE, RD_WAIT, RESP.
- Arbitration is allowed only in IDLE and RESP.
  - Winner is d if d_req=1, unless starve_cnt==STARVE_MAX and if_req=1, in which case IF wins.
  - Otherwise IF wins if if_req=1.
  - Exactly one gnt is high; gnts are 0 in RD_WAIT.
- Grant cycle t:
  - mem_en=1, and mem_addr is the winner's address.
  - mem_we = d_we when d wins, else 0.
  - mem_wdata = d_wdata (don't-care for IF).
  - Outside a grant: mem_en=0, mem_we=0, mem_addr/mem_wdata hold 0.
- Write grant: the access completes in cycle t with no response. The next state is IDLE, so back-to-back writes run at one per cycle.
- Read grant: latch the source (IF/D), load the counter with MEM_LAT-1, go to RD_WAIT.
  - In RD_WAIT, decrement each cycle.
  - In the cycle the counter is 0, capture mem_rdata into the source's rdata register and go to RESP.
  - The rvalid for that source is high for exactly one cycle in RESP (cycle t+MEM_LAT+1).
  - Read-to-response latency = MEM_LAT+1; sustained read throughput = one per MEM_LAT+1 cycles.
- RESP arbitrates like IDLE: a new grant may coincide with the rvalid pulse. The next state is RD_WAIT for a read, IDLE otherwise.
- The non-selected rdata register holds its previous value.
- Starvation counter, updated at each grant:
  - d grant while if_req=1: increment, saturating at STARVE_MAX.
  - IF grant: clear to 0.
  - d grant while if_req=0: clear to 0.
- Requesters must hold req and address stable until gnt. The arbiter does not check this and does not register requests.
- A req dropped before gnt is simply not served.

Decomposition:
- rv32_pkg gains:
  - arb_state_t enum {ARB_IDLE, ARB_RD_WAIT, ARB_RESP}
  - arb_src_t enum {SRC_IF, SRC_D}
  - localparam ARB_LAT_W = 2
- One sub-module is natural: arb_prio_sel. It is combinational and holds the winner select and starvation-override logic, taking if_req, d_req and starve_cnt and producing the grant vector.
- The FSM, counters and response registers stay in mem_port_arbiter.

Test Plan:
- IF read only, MEM_LAT=1, if_addr=0x40, memory returns 0x00000013:
  - if_gnt at t, mem_en=1, mem_addr=0x40.
  - if_rvalid=1 at t+2 with if_rdata=0x00000013; if_gnt=0 at t+1.
- Same-cycle if_req and d_req (d read at 0x100 returning 0xDEADBEEF): d_gnt=1 and if_gnt=0 first, d_rvalid at t+2; if_gnt is granted at t+2 in RESP.
- d writes to 0x10, 0x14, 0x18 on three consecutive cycles: d_gnt=1 every cycle, mem_we=1, no d_rvalid, busy stays 0.
- STARVE_MAX=4, d_req held high (reads) with if_req high: 4 d grants, then the 5th grant goes to IF, then the counter restarts at 0.
- MEM_LAT=3: read grant at t, busy=1 for t+1..t+3, rvalid at t+4; no gnt during t+1..t+3 even with requests.
- rst_n asserted at t+1 of a MEM_LAT=3 read: all outputs 0 immediately, state IDLE, no rvalid after release; the next request is granted normally.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared types for the rv32 core slice.
// Holds the memory-port arbiter state, source and grant encodings.
package rv32_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RD_WAIT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    SRC_IF,
    SRC_D
  } arb_src_t;

  typedef struct packed {
    logic d;
    logic ifetch;
  } arb_gnt_t;

  localparam int ARB_LAT_W    = 2;
  localparam int ARB_STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_prio_sel.sv
// Winner select for the shared memory port.
// Data side has priority unless fetch has been starved.
module arb_prio_sel
  import rv32_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                    if_req,
  input  logic                    d_req,
  input  logic [ARB_STARVE_W-1:0] starve_cnt,
  output arb_gnt_t                gnt
);

  logic starved;

  always_comb begin
    starved    = if_req &&
                 (starve_cnt == ARB_STARVE_W'(STARVE_MAX));
    gnt        = '0;
    gnt.d      = d_req && !starved;
    gnt.ifetch = if_req && !gnt.d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and MEM stage.
// One transaction in flight; reads answer with an rvalid pulse.
module mem_port_arbiter
  import rv32_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [ARB_LAT_W-1:0] LAT_INIT =
    ARB_LAT_W'(MEM_LAT - 1);
  localparam logic [ARB_STARVE_W-1:0] SMAX =
    ARB_STARVE_W'(STARVE_MAX);

  arb_state_t              state;
  arb_src_t                src;
  logic [ARB_LAT_W-1:0]    lat_cnt;
  logic [ARB_STARVE_W-1:0] starve_cnt;
  arb_gnt_t                sel;
  logic                    can_arb;
  logic                    gnt_any;
  logic                    rd_gnt;

  arb_prio_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_sel (
    .if_req    (if_req),
    .d_req     (d_req),
    .starve_cnt(starve_cnt),
    .gnt       (sel)
  );

  assign can_arb   = (state != ARB_RD_WAIT);
  assign if_gnt    = can_arb && sel.ifetch;
  assign d_gnt     = can_arb && sel.d;
  assign gnt_any   = if_gnt || d_gnt;
  assign rd_gnt    = if_gnt || (d_gnt && !d_we);
  assign busy      = (state == ARB_RD_WAIT);

  assign mem_en    = gnt_any;
  assign mem_we    = d_gnt && d_we;
  assign mem_addr  = d_gnt  ? d_addr :
                     if_gnt ? if_addr : '0;
  assign mem_wdata = gnt_any ? d_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      src        <= SRC_IF;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      unique case (state)
        ARB_IDLE, ARB_RESP: begin
          if (rd_gnt) begin
            src     <= d_gnt ? SRC_D : SRC_IF;
            lat_cnt <= LAT_INIT;
            state   <= ARB_RD_WAIT;
          end else begin
            state   <= ARB_IDLE;
          end
        end
        ARB_RD_WAIT: begin
          if (lat_cnt == '0) begin
            state <= ARB_RESP;
            if (src == SRC_D) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
      // Count data wins only while fetch is actually waiting.
      if (d_gnt) begin
        if (!if_req)
          starve_cnt <= '0;
        else if (starve_cnt != SMAX)
          starve_cnt <= starve_cnt + 1'b1;
      end else if (if_gnt) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector tables, reset corner,
// and randomized traffic against a timestamp-based model.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] wd;
    logic [6:0]  ctl;
    logic [31:0] ma;
    logic [31:0] rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic        d_gnt     [2];
  logic        d_rvalid  [2];
  logic [31:0] d_rdata   [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  logic [31:0] mem_arr [2][256];
  logic [31:0] pipe    [2][3];

  int checks = 0;
  int errors = 0;

  int          m_n      [2];
  int          m_free   [2];
  int          m_resp   [2];
  int          m_starve [2];
  bit          m_resp_d [2];
  bit          m_ig     [2];
  bit          m_dg     [2];
  logic [31:0] m_val    [2];
  logic [31:0] m_ifr    [2];
  logic [31:0] m_dr     [2];
  logic [31:0] mmem     [2][256];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]),
    .if_gnt(if_gnt[0]), .if_rvalid(if_rvalid[0]),
    .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]),
    .d_wdata(d_wdata[0]), .d_gnt(d_gnt[0]),
    .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]),
    .if_gnt(if_gnt[1]), .if_rvalid(if_rvalid[1]),
    .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]),
    .d_wdata(d_wdata[1]), .d_gnt(d_gnt[1]),
    .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Memory model: data appears MEM_LAT cycles after the strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe[k][0] <= (mem_en[k] && !mem_we[k]) ?
                    mem_arr[k][mem_addr[k][9:2]] : 32'hBAD0_0000;
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
      if (mem_en[k] && mem_we[k])
        mem_arr[k][mem_addr[k][9:2]] = mem_wdata[k];
    end
  end

  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl_of(input int k);
    return {if_gnt[k], d_gnt[k], mem_en[k], mem_we[k],
            busy[k], if_rvalid[k], d_rvalid[k]};
  endfunction

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] wd,
    input logic [6:0] ctl, input logic [31:0] ma,
    input logic [31:0] rd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
    v.da = da; v.wd = wd; v.ctl = ctl; v.ma = ma; v.rd = rd;
    return v;
  endfunction

  task automatic drive(input int k, input logic ir,
                       input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da,
                       input logic [31:0] wd);
    if_req[k] = ir; if_addr[k] = ia;
    d_req[k] = dr; d_we[k] = dw;
    d_addr[k] = da; d_wdata[k] = wd;
  endtask

  task automatic apply_row(input int k, input vec_t v,
                           input string nm);
    @(posedge clk); #1;
    drive(k, v.ir, v.ia, v.dr, v.dw, v.da, v.wd);
    @(negedge clk);
    chk({nm, "_ctl"}, 32'(ctl_of(k)), 32'(v.ctl));
    chk({nm, "_addr"}, mem_addr[k], v.ma);
    if (!v.ctl[6])
      chk({nm, "_wdata"}, mem_wdata[k],
          v.ctl[5] ? v.wd : 32'h0);
    if (v.ctl[1]) chk({nm, "_ifrd"}, if_rdata[k], v.rd);
    if (v.ctl[0]) chk({nm, "_drd"}, d_rdata[k], v.rd);
  endtask

  task automatic model_step(input int k);
    int lat = (k == 0) ? 1 : 3;
    bit bsy = m_n[k] < m_free[k];
    bit wd  = !bsy && d_req[k] &&
              !(m_starve[k] == SMAX && if_req[k]);
    bit wi  = !bsy && if_req[k] && !wd;
    bit rvi = (m_n[k] == m_resp[k]) && !m_resp_d[k];
    bit rvd = (m_n[k] == m_resp[k]) && m_resp_d[k];
    logic [31:0] ea;
    if (rvi) m_ifr[k] = m_val[k];
    if (rvd) m_dr[k] = m_val[k];
    ea = wd ? d_addr[k] : (wi ? if_addr[k] : 32'h0);
    chk("rnd_ctl", 32'(ctl_of(k)),
        32'({wi, wd, wi | wd, wd & d_we[k], bsy, rvi, rvd}));
    chk("rnd_addr", mem_addr[k], ea);
    if (!wi)
      chk("rnd_wdata", mem_wdata[k], wd ? d_wdata[k] : 32'h0);
    chk("rnd_ifrdata", if_rdata[k], m_ifr[k]);
    chk("rnd_drdata", d_rdata[k], m_dr[k]);
    if (wd) begin
      if (if_req[k])
        m_starve[k] = (m_starve[k] < SMAX) ?
                      m_starve[k] + 1 : SMAX;
      else
        m_starve[k] = 0;
      if (d_we[k]) begin
        mmem[k][d_addr[k][9:2]] = d_wdata[k];
      end else begin
        m_free[k] = m_n[k] + lat + 1;
        m_resp[k] = m_free[k];
        m_resp_d[k] = 1'b1;
        m_val[k] = mmem[k][d_addr[k][9:2]];
      end
    end else if (wi) begin
      m_starve[k] = 0;
      m_free[k] = m_n[k] + lat + 1;
      m_resp[k] = m_free[k];
      m_resp_d[k] = 1'b0;
      m_val[k] = mmem[k][if_addr[k][9:2]];
    end
    m_ig[k] = wi;
    m_dg[k] = wd;
    m_n[k]++;
  endtask

  task automatic drive_random(input int k);
    if (!if_req[k] || m_ig[k]) begin
      if_req[k] = ($urandom_range(0, 2) != 0);
      if_addr[k] = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    end
    if (!d_req[k] || m_dg[k]) begin
      d_req[k] = ($urandom_range(0, 2) != 0);
      d_we[k] = 1'($urandom_range(0, 1));
      d_addr[k] = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      d_wdata[k] = $urandom;
    end
  endtask

  vec_t t0[$];
  vec_t t1[$];
  vec_t z;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      drive(k, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 256; i++) mem_arr[k][i] = 32'(i);
      mem_arr[k][16] = 32'h0000_0013;
      mem_arr[k][64] = 32'hDEAD_BEEF;
    end
    mem_arr[0][32] = 32'h1111_1111;
    mem_arr[0][17] = 32'h2222_2222;

    // Fetch read, shared-cycle priority, write burst, starvation.
    t0.push_back(mk(1,'h40,0,0,0,0,7'b1010000,'h40,0));
    t0.push_back(mk(0,0,0,0,0,0,7'b0000100,0,0));
    t0.push_back(mk(0,0,0,0,0,0,7'b0000010,0,'h13));
    t0.push_back(mk(1,'h80,1,0,'h100,0,7'b0110000,'h100,0));
    t0.push_back(mk(1,'h80,0,0,0,0,7'b0000100,0,0));
    t0.push_back(mk(1,'h80,0,0,0,0,7'b1010001,'h80,'hDEADBEEF));
    t0.push_back(mk(0,0,0,0,0,0,7'b0000100,0,0));
    t0.push_back(mk(0,0,0,0,0,0,7'b0000010,0,'h11111111));
    t0.push_back(mk(0,0,1,1,'h10,'hA1,7'b0111000,'h10,0));
    t0.push_back(mk(0,0,1,1,'h14,'hA2,7'b0111000,'h14,0));
    t0.push_back(mk(0,0,1,1,'h18,'hA3,7'b0111000,'h18,0));
    t0.push_back(mk(0,0,1,0,'h14,0,7'b0110000,'h14,0));
    t0.push_back(mk(0,0,0,0,0,0,7'b0000100,0,0));
    t0.push_back(mk(0,0,0,0,0,0,7'b0000001,0,'hA2));
    t0.push_back(mk(1,'h44,1,0,'h100,0,7'b0110000,'h100,0));
    for (int i = 0; i < 3; i++) begin
      t0.push_back(mk(1,'h44,1,0,'h100,0,7'b0000100,0,0));
      t0.push_back(mk(1,'h44,1,0,'h100,0,7'b0110001,'h100,
                      'hDEADBEEF));
    end
    t0.push_back(mk(1,'h44,1,0,'h100,0,7'b0000100,0,0));
    t0.push_back(mk(1,'h44,1,0,'h100,0,7'b1010001,'h44,
                    'hDEADBEEF));
    t0.push_back(mk(0,0,1,0,'h100,0,7'b0000100,0,0));
    t0.push_back(mk(1,'h44,1,0,'h100,0,7'b0110010,'h100,
                    'h22222222));
    t0.push_back(mk(1,'h44,0,0,0,0,7'b0000100,0,0));
    t0.push_back(mk(1,'h44,0,0,0,0,7'b1010001,'h44,'hDEADBEEF));
    t0.push_back(mk(0,0,0,0,0,0,7'b0000100,0,0));
    t0.push_back(mk(0,0,0,0,0,0,7'b0000010,0,'h22222222));

    // Three-cycle latency: no grants while the read is in flight.
    t1.push_back(mk(1,'h40,0,0,0,0,7'b1010000,'h40,0));
    for (int i = 0; i < 3; i++)
      t1.push_back(mk(1,'h44,1,0,'h100,0,7'b0000100,0,0));
    t1.push_back(mk(1,'h44,1,0,'h100,0,7'b0110010,'h100,'h13));

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ctl", 32'(ctl_of(k)), 32'h0);
      chk("reset_ifrd", if_rdata[k], 32'h0);
      chk("reset_drd", d_rdata[k], 32'h0);
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    foreach (t0[i]) apply_row(0, t0[i], $sformatf("v0_%0d", i));
    drive(0, 0, 0, 0, 0, 0, 0);
    foreach (t1[i]) apply_row(1, t1[i], $sformatf("v1_%0d", i));

    // Reset lands one cycle into the data read granted above.
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    rst_n[1] = 1'b0;
    #1;
    chk("midrst_ctl", 32'(ctl_of(1)), 32'h0);
    chk("midrst_ifrd", if_rdata[1], 32'h0);
    chk("midrst_drd", d_rdata[1], 32'h0);
    chk("midrst_addr", mem_addr[1], 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n[1] = 1'b1;
    z = mk(0,0,0,0,0,0,7'b0000000,0,0);
    for (int i = 0; i < 6; i++) apply_row(1, z, "postrst_idle");
    apply_row(1, mk(0,0,1,0,'h100,0,7'b0110000,'h100,0),
              "postrst_gnt");
    z = mk(0,0,0,0,0,0,7'b0000100,0,0);
    for (int i = 0; i < 3; i++) apply_row(1, z, "postrst_busy");
    apply_row(1, mk(0,0,0,0,0,0,7'b0000001,0,'hDEADBEEF),
              "postrst_resp");

    // Randomized traffic on both latencies.
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      drive(k, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 256; i++) begin
        mem_arr[k][i] = $urandom;
        mmem[k][i] = mem_arr[k][i];
      end
      m_n[k] = 0; m_free[k] = 0; m_resp[k] = -1;
      m_starve[k] = 0; m_resp_d[k] = 1'b0;
      m_ig[k] = 1'b0; m_dg[k] = 1'b0;
      m_val[k] = 0; m_ifr[k] = 0; m_dr[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      drive_random(0);
      drive_random(1);
      @(negedge clk);
      model_step(0);
      model_step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
